// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
// Holds the fetch FSM states, PC step/alignment constants and the buffer entry.
package ifetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifetch_state_e;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous buffer of fetched words with their PCs.
// Flush wins over push; a pop on an empty buffer is ignored.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count == CW'(DEPTH))
  );

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, imem req/gnt/rvalid master and decoder-side buffer.
// Define IFETCH_ALIGN_CHECK_EN to flag misaligned redirects via fetch_fault.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 1;

  ifetch_state_e state;
  ifetch_state_e state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   target;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_n;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic          credit_ok;
  logic          grant;
  logic          push;
  logic          pop;
  logic          fault;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;

  // sticky misaligned-redirect flag, re-evaluated on every redirect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign fetch_fault = fault;
  assign target      = redirect_pc & ALIGN_MASK;
  assign imem_addr   = fetch_pc;
  assign instr_valid = rst_n && (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign grant       = imem_req && imem_gnt;

  // a pop this cycle frees a slot immediately
  assign inflight  = {1'b0, outstanding} + {1'b0, count} - IW'(pop);
  assign credit_ok = inflight < IW'(FIFO_DEPTH);

  // in RUN every outstanding request is fresh, so the oldest one
  // was issued outstanding words behind the current fetch PC
  assign rsp_pc = fetch_pc - (32'(outstanding) << 2);

  assign push_entry = '{instr: imem_rdata, pc: rsp_pc};
  assign instr      = head.instr;
  assign instr_pc   = head.pc;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // next state, issue, push and stale-drop accounting
  always_comb begin
    state_n  = state;
    drop_n   = drop;
    imem_req = 1'b0;
    push     = 1'b0;
    unique case (state)
      RUN: begin
        imem_req = rst_n && !redirect_valid && !fault && credit_ok;
        push     = imem_rvalid && !redirect_valid;
      end
      DRAIN: begin
        if (imem_rvalid) begin
          drop_n = drop - 1'b1;
          if (drop == CW'(1)) state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
    if (redirect_valid) begin
      drop_n  = outstanding - CW'(imem_rvalid);
      state_n = (drop_n == '0) ? RUN : DRAIN;
    end
  end

  // fetch PC, in-flight count and stale-response count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      drop        <= drop_n;
      if (redirect_valid) begin
        fetch_pc <= target;
      end else if (grant) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a 1-cycle memory.
// Expected words are queued at response time and checked on decoder pops.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          pops   = 0;
  logic [31:0] tb_pc  = 32'h0;
  bit          tb_fault = 1'b0;
  bit          gnt_en = 1'b0;
  bit          hold   = 1'b0;
  logic [31:0] prev_grant = 32'h0;
  bit          have_prev = 1'b0;
  bit          saw_wrap  = 1'b0;
  bit          want_first = 1'b0;
  logic [31:0] first_pc = 32'hDEAD_BEEF;
  bit          last_pop = 1'b0;

  // one clock cycle: drive memory, check against the model, advance model
  task automatic tick();
    bit    g, p, rv, stale_pending;
    mreq_t h, m;
    exp_t  e;
    if (mem_q.size() > 0 && !hold) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~mem_q[0].addr;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    imem_gnt = gnt_en;
    #1;
    stale_pending = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].stale) stale_pending = 1'b1;
    g  = imem_req && imem_gnt;
    p  = instr_valid && instr_ready;
    rv = imem_rvalid;
    last_pop = p;
    checks++;
    if (fetch_fault !== tb_fault)
      $display("FAIL fault: got %b want %b", fetch_fault, tb_fault);
    else passes++;
    if (stale_pending || tb_fault || !rst_n || redirect_valid) begin
      checks++;
      if (imem_req !== 1'b0)
        $display("FAIL no_issue: req got %b want 0", imem_req);
      else passes++;
    end
    if (g) begin
      checks++;
      if (imem_addr !== tb_pc)
        $display("FAIL addr: got %h want %h", imem_addr, tb_pc);
      else passes++;
      if (have_prev && prev_grant == 32'hFFFF_FFFC && imem_addr == 32'h0)
        saw_wrap = 1'b1;
      prev_grant = imem_addr;
      have_prev  = 1'b1;
    end
    if (p) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop: unexpected pc %h want none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc)
          $display("FAIL pop: got %h@%h want %h@%h",
                   instr, instr_pc, e.instr, e.pc);
        else passes++;
        if (want_first) begin
          first_pc   = instr_pc;
          want_first = 1'b0;
        end
      end
    end
    if (rv) begin
      h = mem_q.pop_front();
      if (!h.stale && !redirect_valid) begin
        e.instr = ~h.addr;
        e.pc    = h.addr;
        exp_q.push_back(e);
      end
    end
    if (g) begin
      m.addr  = tb_pc;
      m.stale = 1'b0;
      mem_q.push_back(m);
      tb_pc = tb_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      tb_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_ALIGN_CHECK_EN
      tb_fault = (redirect_pc[1:0] != 2'b00);
`endif
    end
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      tb_pc    = 32'h0;
      tb_fault = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain_all();
    gnt_en = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_q.size() != 0 || exp_q.size() != 0) tick();
    end
    checks++;
    if (mem_q.size() != 0 || exp_q.size() != 0 || instr_valid !== 1'b0)
      $display("FAIL drain: mem %0d buf %0d valid %b want 0 0 0",
               mem_q.size(), exp_q.size(), instr_valid);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_ready = 1'b1;
    gnt_en = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0)
      $display("FAIL reset: req %b valid %b fault %b want 0 0 0",
               imem_req, instr_valid, fetch_fault);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_issue: req %b addr %h want 1 0", imem_req, imem_addr);
    else passes++;
  endtask

  task automatic test_stream();
    pops = 0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (pops !== 10)
      $display("FAIL stream_rate: pops %0d want 10", pops);
    else passes++;
  endtask

  task automatic test_backpressure();
    drain_all();
    do_reset();
    gnt_en = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0)
      $display("FAIL bp_full: req %b valid %b pc %h want 0 1 0",
               imem_req, instr_valid, instr_pc);
    else passes++;
    instr_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1)
      $display("FAIL bp_credit: req %b want 1", imem_req);
    else passes++;
    pops = 0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pops < 4)
      $display("FAIL bp_release: pops %0d want >=4", pops);
    else passes++;
  endtask

  task automatic test_redirect_drain();
    drain_all();
    do_reset();
    gnt_en = 1'b1;
    instr_ready = 1'b1;
    hold = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    hold = 1'b0;
    want_first = 1'b1;
    first_pc = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (imem_req !== 1'b0)
      $display("FAIL drain_req: req %b want 0", imem_req);
    else passes++;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (first_pc !== 32'h0000_0100)
      $display("FAIL drain_first: pc %h want 00000100", first_pc);
    else passes++;
  endtask

  task automatic test_redirect_pop();
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (last_pop !== 1'b1)
      $display("FAIL rp_pop: pop %b want 1", last_pop);
    else passes++;
    #1;
    checks++;
    if (instr_valid !== 1'b0)
      $display("FAIL rp_empty: valid %b want 0", instr_valid);
    else passes++;
    want_first = 1'b1;
    first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (first_pc !== 32'h0000_0300)
      $display("FAIL rp_first: pc %h want 00000300", first_pc);
    else passes++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    saw_wrap = 1'b0;
    have_prev = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (saw_wrap !== 1'b1)
      $display("FAIL wrap: seen %b want 1", saw_wrap);
    else passes++;
  endtask

  task automatic test_align();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    #1;
    checks++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL align_fault: fault %b req %b want 1 0",
               fetch_fault, imem_req);
    else passes++;
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    want_first = 1'b1;
    first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (first_pc !== 32'h0000_0200 || fetch_fault !== 1'b0)
      $display("FAIL align_resume: pc %h fault %b want 00000200 0",
               first_pc, fetch_fault);
    else passes++;
`else
    want_first = 1'b1;
    first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (first_pc !== 32'h0000_0100 || fetch_fault !== 1'b0)
      $display("FAIL align_mask: pc %h fault %b want 00000100 0",
               first_pc, fetch_fault);
    else passes++;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_pop();
    test_wrap();
    test_align();
    drain_all();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
